result_writer: RTL and testbench

RESULT_WRITER -- requirements
Module: result_writer

---
 rtl/result_writer_pkg.sv | 20 ++
 rtl/result_writer_if.sv | 34 +++
 rtl/result_fifo.sv | 70 +++++++
 rtl/result_writer.sv | 108 ++++++++++
 tb/tb_result_writer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/result_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module : result_writer_pkg
// Brief  : Shared widths and FSM state encoding for the result writer.
// Rev    : 1.0
// ============================================================================
package result_writer_pkg;

  localparam int SUM_W  = 21;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/result_writer_if.sv
`default_nettype none
// ============================================================================
// Module : result_writer_if
// Brief  : MAC-side capture inputs, result RAM write port and run status.
// Rev    : 1.0
// ============================================================================
interface result_writer_if #(
  parameter int ADDR_W = 6
);
  import result_writer_pkg::*;

  logic              start;
  logic              web_in;
  logic [SUM_W-1:0]  sum_in;
  logic              ram_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output start, web_in, sum_in, ram_ready,
    input  ram_we, ram_addr, ram_wdata, busy, done, overflow
  );

  modport slave (
    input  start, web_in, sum_in, ram_ready,
    output ram_we, ram_addr, ram_wdata, busy, done, overflow
  );

endinterface
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module : result_fifo
// Brief  : Small synchronous FIFO with simultaneous push/pop and sync clear.
// Rev    : 1.0
// ============================================================================
module result_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   C_FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign full    = (r_count == C_FULL);
  assign empty   = (r_count == '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_wr_en = push && (!full || pop);
  assign w_rd_en = pop && !empty;
  assign rdata   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_writer.sv
`default_nettype none
// ============================================================================
// Module : result_writer
// Brief  : Captures NUM_RESULTS MAC sums per run and streams them to a RAM.
// Rev    : 1.0
// ============================================================================
module result_writer
  import result_writer_pkg::*;
#(
  parameter int NUM_RESULTS = 16,
  parameter int ADDR_W      = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  result_writer_if.slave bus
);

  localparam int            CW     = $clog2(NUM_RESULTS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_RESULTS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cap_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_overflow;

  logic              w_start_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_we;
  logic              w_last;
  logic              w_full;
  logic              w_empty;
  logic [SUM_W-1:0]  w_head;

  assign w_start_ok = (r_state == IDLE) && bus.start;
  assign w_push     = (r_state == RUN) && bus.web_in;
  assign w_we       = ((r_state == RUN) || (r_state == DRAIN)) && !w_empty;
  assign w_pop      = w_we && bus.ram_ready;
  // Dropped sums count too, so a run always ends after NUM_RESULTS strobes.
  assign w_last     = w_push && (r_cap_cnt == C_LAST);

  result_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_start_ok),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (bus.sum_in),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DRAIN;
      DRAIN:   if (w_empty)   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_cnt  <= '0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_cap_cnt  <= '0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_cap_cnt <= r_cap_cnt + CW'(1);
      end
      if (w_pop) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.ram_we    = w_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = DATA_W'(w_head);
  assign bus.busy      = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done      = (r_state == DONE);
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_result_writer
// Brief  : Directed, table-driven bench with a write scoreboard for result_writer.
// Rev    : 1.0
// ============================================================================
module tb_result_writer;
  import result_writer_pkg::*;

  localparam int NUM_RESULTS = 16;
  localparam int ADDR_W      = 4;
  localparam int FIFO_DEPTH  = 4;

  typedef struct packed {
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] exp;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_writer_if #(.ADDR_W(ADDR_W)) bus ();

  result_writer #(
    .NUM_RESULTS (NUM_RESULTS),
    .ADDR_W      (ADDR_W),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                checks   = 0;
  int                errors   = 0;
  int                done_cnt = 0;
  wr_t               sb[$];
  logic [ADDR_W-1:0] exp_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every completed RAM write must match the scoreboard head,
  // and a stalled write must hold its request unchanged.
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] stall_addr;
  logic [DATA_W-1:0] stall_data;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      wr_t e;
      if (stall_prev) begin
        check("hold_we", bus.ram_we, 1'b1);
        check("hold_addr", bus.ram_addr, stall_addr);
        check("hold_data", bus.ram_wdata, stall_data);
      end
      if (bus.ram_we && bus.ram_ready) begin
        check("write_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", bus.ram_addr, e.addr);
          check("wr_data", bus.ram_wdata, e.data);
        end
      end
      stall_prev = bus.ram_we && !bus.ram_ready;
      stall_addr = bus.ram_addr;
      stall_data = bus.ram_wdata;
      if (bus.done) done_cnt++;
    end
  end

  task automatic wait_done(input string tag, input int base);
    int n = 0;
    while (done_cnt == base && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({tag, "_done_pulses"}, done_cnt - base, 1);
  endtask

  task automatic run_table(input vec_t v[NUM_RESULTS], input bit start_mid,
                           input bit stall, input string tag);
    int base;
    base          = done_cnt;
    exp_addr      = '0;
    bus.ram_ready = !stall;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, bus.busy, 1'b1);
    check({tag, "_ovf_clear"}, bus.overflow, 1'b0);
    for (int i = 0; i < NUM_RESULTS; i++) begin
      bus.web_in = 1'b1;
      bus.sum_in = v[i].sum;
      bus.start  = start_mid && (i == 5);
      // With the RAM stalled only the first FIFO_DEPTH sums fit; later ones drop.
      if (!stall || i < FIFO_DEPTH) begin
        sb.push_back('{addr: exp_addr, data: v[i].exp});
        exp_addr = exp_addr + ADDR_W'(1);
      end
      tick();
    end
    bus.web_in = 1'b0;
    bus.start  = 1'b0;
    if (stall) begin
      check({tag, "_ovf_set"}, bus.overflow, 1'b1);
      repeat (2) tick();
      bus.ram_ready = 1'b1;
    end
    wait_done(tag, base);
    check({tag, "_ovf_final"}, bus.overflow, stall);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_busy_end"}, bus.busy, 1'b0);
    check({tag, "_end_addr"}, bus.ram_addr, exp_addr);
    check({tag, "_no_x"}, $isunknown({bus.ram_we, bus.ram_addr, bus.ram_wdata,
                                      bus.busy, bus.done, bus.overflow}), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl_seq[NUM_RESULTS];
    vec_t tbl_pat[NUM_RESULTS];
    vec_t tbl_ovf[NUM_RESULTS];

    for (int i = 0; i < NUM_RESULTS; i++) begin
      tbl_seq[i].sum = SUM_W'(i);
      tbl_seq[i].exp = DATA_W'(i);
      tbl_ovf[i].sum = SUM_W'(100 + i);
      tbl_ovf[i].exp = DATA_W'(100 + i);
    end
    tbl_pat = '{
      '{21'h1FFFFF, 32'h001FFFFF}, '{21'h000000, 32'h00000000},
      '{21'h100000, 32'h00100000}, '{21'h0ABCDE, 32'h000ABCDE},
      '{21'h155555, 32'h00155555}, '{21'h0AAAAA, 32'h000AAAAA},
      '{21'h000001, 32'h00000001}, '{21'h1FFFFE, 32'h001FFFFE},
      '{21'h0F0F0F, 32'h000F0F0F}, '{21'h10F0F0, 32'h0010F0F0},
      '{21'h012345, 32'h00012345}, '{21'h1E0000, 32'h001E0000},
      '{21'h00FFFF, 32'h0000FFFF}, '{21'h1F0000, 32'h001F0000},
      '{21'h0007FF, 32'h000007FF}, '{21'h1FFFFF, 32'h001FFFFF}
    };

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.web_in    = 1'b0;
    bus.sum_in    = '0;
    bus.ram_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_we", bus.ram_we, 1'b0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_wdata", bus.ram_wdata, 0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    tick();
    rst = 1'b0;

    // web_in while idle must not enqueue anything.
    bus.web_in = 1'b1;
    bus.sum_in = 21'h1234;
    repeat (3) tick();
    bus.web_in = 1'b0;
    check("idle_web_busy", bus.busy, 1'b0);
    check("idle_web_we", bus.ram_we, 1'b0);

    run_table(tbl_seq, 1'b0, 1'b0, "seq");
    run_table(tbl_pat, 1'b0, 1'b0, "pat");
    run_table(tbl_seq, 1'b0, 1'b0, "wrap2");
    run_table(tbl_ovf, 1'b0, 1'b1, "ovf");
    run_table(tbl_seq, 1'b1, 1'b0, "midstart");

    // Reset mid-run: the three buffered sums must never reach the RAM.
    bus.ram_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.web_in = 1'b1;
      bus.sum_in = SUM_W'(21'h0DEAD + i);
      tick();
    end
    bus.web_in = 1'b0;
    check("pre_rst_we", bus.ram_we, 1'b1);
    rst = 1'b1;
    repeat (2) tick();
    check("mid_rst_we", bus.ram_we, 1'b0);
    check("mid_rst_addr", bus.ram_addr, 0);
    check("mid_rst_busy", bus.busy, 1'b0);
    rst           = 1'b0;
    bus.ram_ready = 1'b1;
    repeat (3) tick();
    check("post_rst_we", bus.ram_we, 1'b0);
    run_table(tbl_pat, 1'b0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
